barrel_normalize: RTL
=====================

Name: barrel_normalize

Overview:
- Pipelined normalizer: the inverse of the barrel shifter.
- It takes a data word, finds the shift amount that brings the first set bit to the edge (leading or trailing zero count), and returns both the normalized word and that shift amount.
- Used ahead of the shifter in float pack/unpack and priority-scaling paths. Feeding `out_shamt` back through the shifter in the opposite direction recovers the input.
- Valid/ready streaming interface, one stage per shift-amount bit, full throughput.

Parameters:
- `LENGTH`, 8: data width. Must be a power of two, ≥ 4. `S = $clog2(LENGTH)` is the number of stages.
- `LEFT`, 1:
  - 1 = normalize toward MSB: count leading zeros, shift left.
  - 0 = normalize toward LSB: count trailing zeros, shift right.

Ports:
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `in_valid`  in  1  input word present
- `in_ready`  out  1  block accepts input this cycle
- `in_data`  in  LENGTH  word to normalize
- `out_valid`  out  1  result present
- `out_ready`  in  1  consumer accepts result this cycle
- `out_data`  out  LENGTH  normalized word
- `out_shamt`  out  S  shift applied = leading (`LEFT=1`) or trailing (`LEFT=0`) zero count
- `out_zero`  out  1  input was all zeros

Behaviour:
- **Clock and reset:** one clock; reset is asynchronous and active-low.
- **Reset state:** all stage valid bits 0, so `out_valid=0`. `out_data`, `out_shamt` and `out_zero` are 0. `in_ready=1` from the first cycle after `rst_n` rises.
- **Pipeline structure:**
  - S register stages, k = S-1 down to 0, processed in that order (largest first).
  - Stage for bit k inspects the 2^k bits at the normalizing edge of its incoming word:
    - `LEFT=1`: the top 2^k bits.
    - `LEFT=0`: the bottom 2^k bits.
  - If those bits are all zero, the stage shifts the word by 2^k (left for `LEFT=1`, right for `LEFT=0`, zero fill) and sets `shamt[k]=1`. Otherwise it passes the word through with `shamt[k]=0`.
  - `shamt` bits accumulate down the pipe; lower bits are 0 until written by their stage.
- **Zero input:**
  - Every stage shifts, so `out_shamt = LENGTH-1` and `out_data = 0`.
  - `out_zero = (out_data == 0)` at the output stage. It is 1 only for all-zero input.
- **Latency and throughput:**
  - Exactly S cycles from input accept to `out_valid`, with no stalls.
  - One result per cycle sustained.
- **Advance rule:**
  - `advance = !out_valid || out_ready`.
  - All stages load together when `advance=1`, and hold every register when `advance=0`.
  - `in_ready = advance` (combinational; no skid buffer).
  - A bubble propagates as `valid=0`. Bubbles are not compressed; the global stall is sufficient.
- **Handshake:**
  - Input transfers when `in_valid && in_ready`.
  - Output transfers when `out_valid && out_ready`.
  - `out_data`, `out_shamt` and `out_zero` stay stable while `out_valid=1` and `out_ready=0`.
  - `in_valid=0` with `advance=1` inserts a bubble.
- **Simultaneous accept and release:** when `out_valid=1`, `out_ready=1` and `in_valid=1` all hold in one cycle, the output retires and the input enters stage S-1 in the same edge. No loss and no duplication.
- **Reset mid-operation:** asserting `rst_n=0` at any time clears all valids immediately (asynchronous). In-flight words are discarded and never emitted.
- **Data path registers:** data registers of invalid stages may hold stale values but must be reset to 0. Outputs depend on the output stage only.

Decomposition:
- Package `barrel_pkg`:
  - function `shamt_width(LENGTH)` returning `$clog2(LENGTH)`.
  - shared `LEFT`/`RIGHT` localparams, reused by the shifter.
- Sub-module `normalize_stage`:
  - Parameters: `LENGTH`, `K`, `LEFT`.
  - Logic: one conditional 2^K shift plus a zero-detect on the edge field, registered with valid, data and partial shamt. It loads on the shared `advance`.
- The top level generates S instances and holds the advance/ready logic.

Test Plan (`LENGTH=8`, `S=3`):
- `LEFT=1`, `in_data=0x13`, `out_ready=1` → 3 cycles later `out_data=0x98`, `out_shamt=3`, `out_zero=0`.
- `LEFT=1`, inputs 0x80, 0x01, 0x00 back-to-back → consecutive outputs:
  - (0x80, 0, 0)
  - (0x80, 7, 0)
  - (0x00, 7, 1)
- `LEFT=0`, `in_data=0x58` → `out_data=0x0B`, `out_shamt=3`; `in_data=0x01` → `out_data=0x01`, `out_shamt=0`.
- Back-pressure:
  - Stream 0x01..0x06 with `out_ready=0` for cycles 0–7: `in_ready` drops after 3 accepts, and the output holds the 0x01 result stable.
  - Raising `out_ready` yields all 6 results in order, with no gaps once flowing and no drops.
- Random stream with random `in_valid`/`out_ready`: scoreboard checks, for each result:
  - `out_shamt` matches a reference count.
  - Shifting `out_data` back by `out_shamt` in the opposite direction restores the input.
- Reset mid-operation: assert `rst_n=0` with 3 words in flight for 1 cycle → `out_valid=0` at once; after release, no stale result is emitted and the next accepted word appears 3 cycles later.

Source files
------------

// File: rtl/barrel_pkg.sv
// Shared definitions for the barrel shifter / normalizer family.
// Direction encodings and shift-amount width helper.
package barrel_pkg;

  localparam bit DIR_LEFT  = 1'b1;
  localparam bit DIR_RIGHT = 1'b0;

  function automatic int shamt_width(input int length);
    return $clog2(length);
  endfunction

endpackage

// File: rtl/normalize_stage.sv
// One normalizer stage: conditional 2^K shift when the edge field
// is all zero, registered with valid and partial shift amount.
module normalize_stage
  import barrel_pkg::*;
#(
  parameter int LENGTH = 8,
  parameter int K      = 0,
  parameter bit LEFT   = DIR_LEFT
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           advance_i,
  input  logic                           valid_i,
  input  logic [LENGTH-1:0]              data_i,
  input  logic [shamt_width(LENGTH)-1:0] shamt_i,
  output logic                           valid_o,
  output logic [LENGTH-1:0]              data_o,
  output logic [shamt_width(LENGTH)-1:0] shamt_o
);

  localparam int S = shamt_width(LENGTH);
  localparam int W = 1 << K;

  logic              edge_zero;
  logic [LENGTH-1:0] data_d;
  logic [S-1:0]      shamt_d;
  logic              valid_q;
  logic [LENGTH-1:0] data_q;
  logic [S-1:0]      shamt_q;

  if (LEFT == DIR_LEFT) begin : g_left
    assign edge_zero = (data_i[LENGTH-1 -: W] == '0);
  end else begin : g_right
    assign edge_zero = (data_i[W-1:0] == '0);
  end

  always_comb begin
    shamt_d    = shamt_i;
    shamt_d[K] = edge_zero;
    data_d     = data_i;
    if (edge_zero) begin
      if (LEFT == DIR_LEFT) data_d = data_i << W;
      else                  data_d = data_i >> W;
    end
  end

  // Data loads even for bubbles; only the valid bit gives it meaning.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      shamt_q <= '0;
    end else if (advance_i) begin
      valid_q <= valid_i;
      data_q  <= data_d;
      shamt_q <= shamt_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign shamt_o = shamt_q;

endmodule

// File: rtl/barrel_normalize.sv
// Pipelined normalizer: leading/trailing zero count plus the
// normalized word, one stage per shift-amount bit.
module barrel_normalize
  import barrel_pkg::*;
#(
  parameter int LENGTH = 8,
  parameter bit LEFT   = DIR_LEFT
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [LENGTH-1:0]              in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [LENGTH-1:0]              out_data,
  output logic [shamt_width(LENGTH)-1:0] out_shamt,
  output logic                           out_zero
);

  localparam int S = shamt_width(LENGTH);

  logic              advance;
  logic [S:0]        vld;
  logic [LENGTH-1:0] dat [S+1];
  logic [S-1:0]      sh  [S+1];

  // Global stall: the whole pipe moves whenever the output can drain.
  assign advance  = !vld[0] || out_ready;
  assign in_ready = advance;

  assign vld[S] = in_valid;
  assign dat[S] = in_data;
  assign sh[S]  = '0;

  for (genvar k = S - 1; k >= 0; k--) begin : g_stage
    normalize_stage #(
      .LENGTH (LENGTH),
      .K      (k),
      .LEFT   (LEFT)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .advance_i (advance),
      .valid_i   (vld[k+1]),
      .data_i    (dat[k+1]),
      .shamt_i   (sh[k+1]),
      .valid_o   (vld[k]),
      .data_o    (dat[k]),
      .shamt_o   (sh[k])
    );
  end

  assign out_valid = vld[0];
  assign out_data  = dat[0];
  assign out_shamt = sh[0];
  assign out_zero  = vld[0] && (dat[0] == '0);

endmodule
